// File: rtl/rom_access_seq_if.sv
// External cartridge memory bus between the access sequencer and the ROM/SRAM device.
// The sequencer is the master; the memory (or a bench) is the slave.
interface rom_access_seq_if;
    logic [22:0] ROM_A;
    logic [15:0] ROM_DQ_IN;
    logic [15:0] ROM_DQ_OUT;
    logic        ROM_DQ_OE;
    logic        ROM_CE_N;
    logic        ROM_OE_N;
    logic        ROM_WE_N;
    logic        ROM_BHE_N;
    logic        ROM_BLE_N;

    modport master (
        output ROM_A,
        output ROM_DQ_OUT,
        output ROM_DQ_OE,
        output ROM_CE_N,
        output ROM_OE_N,
        output ROM_WE_N,
        output ROM_BHE_N,
        output ROM_BLE_N,
        input  ROM_DQ_IN
    );

    modport slave (
        input  ROM_A,
        input  ROM_DQ_OUT,
        input  ROM_DQ_OE,
        input  ROM_CE_N,
        input  ROM_OE_N,
        input  ROM_WE_N,
        input  ROM_BHE_N,
        input  ROM_BLE_N,
        output ROM_DQ_IN
    );
endinterface

// File: rtl/rom_access_seq.sv
// Arbitrates SNES and MCU byte accesses onto a 16-bit external memory, one fixed-length
// strobe cycle at a time, with a mandatory idle clock between cycles.
//
// state | meaning
// IDLE  | no cycle; strobes released, next pending request may start
// SRD   | SNES read cycle, result lands in SNES_DOUT
// SWR   | SNES write cycle
// MRD   | MCU read cycle, result lands in MCU_DIN
// MWR   | MCU write cycle
module rom_access_seq #(
    parameter int ROM_CYCLE_LEN = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNES_RD_START,
    input  logic        SNES_WR_END,
    input  logic [23:0] ROM_ADDR,
    input  logic        ROM_HIT,
    input  logic        IS_WRITABLE,
    input  logic [7:0]  SNES_DATA_IN,
    output logic [7:0]  SNES_DOUT,
    input  logic        MCU_RRQ,
    input  logic        MCU_WRQ,
    input  logic [23:0] MCU_ADDR,
    input  logic [7:0]  MCU_DOUT,
    output logic        MCU_RDY,
    output logic [7:0]  MCU_DIN,
    rom_access_seq_if.master rom
);

    localparam logic [3:0] CNT_INIT = 4'(ROM_CYCLE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SRD,
        SWR,
        MRD,
        MWR
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        s_pend_q, s_pend_d;
    logic        s_wr_q, s_wr_d;
    logic [23:0] s_addr_q, s_addr_d;
    logic [7:0]  s_data_q, s_data_d;

    logic        m_pend_q, m_pend_d;
    logic        m_wr_q, m_wr_d;
    logic [23:0] m_addr_q, m_addr_d;
    logic [7:0]  m_data_q, m_data_d;

    logic [7:0]  snes_dout_q, snes_dout_d;
    logic [7:0]  mcu_din_q, mcu_din_d;

    logic        snes_rd_acc;
    logic        snes_wr_acc;
    logic        mcu_busy;
    logic        mcu_acc;
    logic        cyc_active;
    logic        cyc_write;
    logic        cyc_read;
    logic [7:0]  rd_byte;

    assign snes_rd_acc = SNES_RD_START & ROM_HIT;
    assign snes_wr_acc = SNES_WR_END & IS_WRITABLE & ~snes_rd_acc;

    // MCU is busy while its request waits or runs; a pulse then is a protocol error and dropped.
    assign mcu_busy = m_pend_q | (state_q == MRD) | (state_q == MWR);
    assign mcu_acc  = (MCU_RRQ | MCU_WRQ) & ~mcu_busy;

    assign cyc_active = (state_q != IDLE);
    assign cyc_write  = (state_q == SWR) | (state_q == MWR);
    assign cyc_read   = (state_q == SRD) | (state_q == MRD);
    assign rd_byte    = addr_q[0] ? rom.ROM_DQ_IN[15:8] : rom.ROM_DQ_IN[7:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 24'd0;
            wdata_q     <= 8'd0;
            s_pend_q    <= 1'b0;
            s_wr_q      <= 1'b0;
            s_addr_q    <= 24'd0;
            s_data_q    <= 8'd0;
            m_pend_q    <= 1'b0;
            m_wr_q      <= 1'b0;
            m_addr_q    <= 24'd0;
            m_data_q    <= 8'd0;
            snes_dout_q <= 8'd0;
            mcu_din_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            s_pend_q    <= s_pend_d;
            s_wr_q      <= s_wr_d;
            s_addr_q    <= s_addr_d;
            s_data_q    <= s_data_d;
            m_pend_q    <= m_pend_d;
            m_wr_q      <= m_wr_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            snes_dout_q <= snes_dout_d;
            mcu_din_q   <= mcu_din_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        s_pend_d    = s_pend_q;
        s_wr_d      = s_wr_q;
        s_addr_d    = s_addr_q;
        s_data_d    = s_data_q;
        m_pend_d    = m_pend_q;
        m_wr_d      = m_wr_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        snes_dout_d = snes_dout_q;
        mcu_din_d   = mcu_din_q;

        // A fresh SNES request always replaces an older one still waiting.
        if (snes_rd_acc | snes_wr_acc) begin
            s_pend_d = 1'b1;
            s_wr_d   = snes_wr_acc;
            s_addr_d = ROM_ADDR;
            s_data_d = SNES_DATA_IN;
        end
        if (mcu_acc) begin
            m_pend_d = 1'b1;
            m_wr_d   = MCU_WRQ & ~MCU_RRQ;
            m_addr_d = MCU_ADDR;
            m_data_d = MCU_DOUT;
        end

        case (state_q)
            IDLE: begin
                if (s_pend_d) begin
                    state_d  = s_wr_d ? SWR : SRD;
                    cnt_d    = CNT_INIT;
                    addr_d   = s_addr_d;
                    wdata_d  = s_data_d;
                    s_pend_d = 1'b0;
                end else if (m_pend_d) begin
                    state_d  = m_wr_d ? MWR : MRD;
                    cnt_d    = CNT_INIT;
                    addr_d   = m_addr_d;
                    wdata_d  = m_data_d;
                    m_pend_d = 1'b0;
                end
            end
            default: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Always return through IDLE so the bus gets its recovery clock.
                    state_d = IDLE;
                    if (state_q == SRD) snes_dout_d = rd_byte;
                    if (state_q == MRD) mcu_din_d   = rd_byte;
                end
            end
        endcase
    end

    assign rom.ROM_A      = addr_q[23:1];
    assign rom.ROM_DQ_OUT = {wdata_q, wdata_q};
    assign rom.ROM_DQ_OE  = cyc_write;
    assign rom.ROM_CE_N   = ~cyc_active;
    assign rom.ROM_OE_N   = ~cyc_read;
    assign rom.ROM_WE_N   = ~(cyc_write & (cnt_q != 4'd0));
    assign rom.ROM_BHE_N  = ~(cyc_active & addr_q[0]);
    assign rom.ROM_BLE_N  = ~(cyc_active & ~addr_q[0]);

    assign SNES_DOUT = snes_dout_q;
    assign MCU_DIN   = mcu_din_q;
    assign MCU_RDY   = ~mcu_busy;

endmodule

// File: tb/tb_rom_access_seq.sv
// Bench for rom_access_seq: directed vector table, multi-cycle corner sequences and random
// traffic, all checked against a timestamp-based transaction model.
module tb_rom_access_seq;

    localparam int L = 6;

    logic        CLK;
    logic        RST;
    logic        SNES_RD_START, SNES_WR_END;
    logic [23:0] ROM_ADDR;
    logic        ROM_HIT, IS_WRITABLE;
    logic [7:0]  SNES_DATA_IN, SNES_DOUT;
    logic        MCU_RRQ, MCU_WRQ;
    logic [23:0] MCU_ADDR;
    logic [7:0]  MCU_DOUT, MCU_DIN;
    logic        MCU_RDY;

    rom_access_seq_if rif ();

    rom_access_seq #(.ROM_CYCLE_LEN(L)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SNES_RD_START(SNES_RD_START),
        .SNES_WR_END  (SNES_WR_END),
        .ROM_ADDR     (ROM_ADDR),
        .ROM_HIT      (ROM_HIT),
        .IS_WRITABLE  (IS_WRITABLE),
        .SNES_DATA_IN (SNES_DATA_IN),
        .SNES_DOUT    (SNES_DOUT),
        .MCU_RRQ      (MCU_RRQ),
        .MCU_WRQ      (MCU_WRQ),
        .MCU_ADDR     (MCU_ADDR),
        .MCU_DOUT     (MCU_DOUT),
        .MCU_RDY      (MCU_RDY),
        .MCU_DIN      (MCU_DIN),
        .rom          (rif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Model: an access is a record stamped with the edge it began on; it owns the bus for
    // L edges, completes on the L-th edge after its start, and the next may begin one edge later.
    typedef struct {
        logic        v;
        logic        wr;
        logic        mcu;
        logic [23:0] addr;
        logic [7:0]  data;
        int          start;
    } acc_t;

    acc_t       act, s_slot, m_slot;
    int         edge_n = 0;
    logic [7:0] m_sdout, m_mdin;

    task automatic model_edge();
        logic mcu_busy, done;
        edge_n++;
        if (RST) begin
            act.v = 1'b0; s_slot.v = 1'b0; m_slot.v = 1'b0;
            m_sdout = 8'h00; m_mdin = 8'h00;
            return;
        end
        mcu_busy = m_slot.v || (act.v && act.mcu);
        done     = act.v && (edge_n - act.start == L);
        if (done) begin
            if (!act.wr) begin
                if (act.mcu) m_mdin  = act.addr[0] ? rif.ROM_DQ_IN[15:8] : rif.ROM_DQ_IN[7:0];
                else         m_sdout = act.addr[0] ? rif.ROM_DQ_IN[15:8] : rif.ROM_DQ_IN[7:0];
            end
            act.v = 1'b0;
        end
        if (SNES_RD_START && ROM_HIT)
            s_slot = '{v:1'b1, wr:1'b0, mcu:1'b0, addr:ROM_ADDR, data:SNES_DATA_IN, start:0};
        else if (SNES_WR_END && IS_WRITABLE)
            s_slot = '{v:1'b1, wr:1'b1, mcu:1'b0, addr:ROM_ADDR, data:SNES_DATA_IN, start:0};
        if ((MCU_RRQ || MCU_WRQ) && !mcu_busy)
            m_slot = '{v:1'b1, wr:MCU_WRQ && !MCU_RRQ, mcu:1'b1, addr:MCU_ADDR, data:MCU_DOUT, start:0};
        if (!act.v && !done) begin
            if (s_slot.v) begin
                act = s_slot; act.start = edge_n; s_slot.v = 1'b0;
            end else if (m_slot.v) begin
                act = m_slot; act.start = edge_n; m_slot.v = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [5:0] exp_s, got_s;
        int age;
        exp_s = 6'b111110;  // {ce,oe,we,bhe,ble,dq_oe}
        if (act.v) begin
            age   = edge_n - act.start;
            exp_s = {1'b0, act.wr, !(act.wr && age != L - 1), !act.addr[0], act.addr[0], act.wr};
            check("rom_a", 32'(rif.ROM_A), 32'(act.addr[23:1]));
            if (act.wr) check("dq_out", 32'(rif.ROM_DQ_OUT), {16'h0, act.data, act.data});
        end
        got_s = {rif.ROM_CE_N, rif.ROM_OE_N, rif.ROM_WE_N, rif.ROM_BHE_N, rif.ROM_BLE_N, rif.ROM_DQ_OE};
        check("strobes", 32'(got_s), 32'(exp_s));
        check("mcu_rdy", 32'(MCU_RDY), 32'(!(m_slot.v || (act.v && act.mcu))));
        check("snes_dout", 32'(SNES_DOUT), 32'(m_sdout));
        check("mcu_din", 32'(MCU_DIN), 32'(m_mdin));
    endtask

    logic        prev_ce = 1'b1;
    int          n_starts;
    logic [22:0] last_a;
    logic        last_oe;

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
        if (prev_ce && !rif.ROM_CE_N) begin
            n_starts++;
            last_a  = rif.ROM_A;
            last_oe = rif.ROM_OE_N;
        end
        prev_ce = rif.ROM_CE_N;
        SNES_RD_START = 1'b0; SNES_WR_END = 1'b0; MCU_RRQ = 1'b0; MCU_WRQ = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  src;       // 0 snes rd, 1 snes wr, 2 mcu rd, 3 mcu wr
        logic        en;        // ROM_HIT for snes rd, IS_WRITABLE for snes wr
        logic [23:0] addr;
        logic [7:0]  data;
        logic [15:0] dq;
        logic        exp_cyc;
        logic [22:0] exp_a;
        logic        exp_bhe_n;
        logic        exp_ble_n;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        RST = 1'b1; SNES_RD_START = 1'b0; SNES_WR_END = 1'b0; ROM_ADDR = '0; ROM_HIT = 1'b0;
        IS_WRITABLE = 1'b0; SNES_DATA_IN = '0; MCU_RRQ = 1'b0; MCU_WRQ = 1'b0; MCU_ADDR = '0;
        MCU_DOUT = '0; rif.ROM_DQ_IN = '0;
        act = '{v:1'b0, wr:1'b0, mcu:1'b0, addr:24'h0, data:8'h0, start:0};
        s_slot = act; m_slot = act; m_sdout = 8'h00; m_mdin = 8'h00;

        vecs[0] = '{2'd0, 1'b1, 24'h012345, 8'h00, 16'hA55A, 1'b1, 23'h0091A2, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{2'd1, 1'b0, 24'hE00010, 8'h3C, 16'h0000, 1'b0, 23'h000000, 1'b1, 1'b1, 8'h00};
        vecs[2] = '{2'd1, 1'b1, 24'hE00010, 8'h3C, 16'h0000, 1'b1, 23'h700008, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{2'd0, 1'b0, 24'h000100, 8'h00, 16'hFFFF, 1'b0, 23'h000000, 1'b1, 1'b1, 8'h00};
        vecs[4] = '{2'd2, 1'b1, 24'h000100, 8'h00, 16'h1234, 1'b1, 23'h000080, 1'b1, 1'b0, 8'h34};
        vecs[5] = '{2'd3, 1'b1, 24'h7FFFFF, 8'h81, 16'h0000, 1'b1, 23'h3FFFFF, 1'b0, 1'b1, 8'h00};
        vecs[6] = '{2'd0, 1'b1, 24'hFFFFFE, 8'h00, 16'hBEEF, 1'b1, 23'h7FFFFF, 1'b1, 1'b0, 8'hEF};
        vecs[7] = '{2'd2, 1'b1, 24'h000001, 8'h00, 16'hC30F, 1'b1, 23'h000000, 1'b0, 1'b1, 8'hC3};

        step(); step();
        check("reset_rom_a", 32'(rif.ROM_A), 32'h0);
        check("reset_dq_out", 32'(rif.ROM_DQ_OUT), 32'h0);
        RST = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            int ce_low, oe_low, we_low, exp_oe, exp_we;
            logic got_a_seen;
            logic [22:0] got_a;
            logic got_bhe, got_ble;
            logic [15:0] got_dq;
            ce_low = 0; oe_low = 0; we_low = 0; got_a_seen = 1'b0;
            got_a = '0; got_bhe = 1'b1; got_ble = 1'b1; got_dq = '0;
            rif.ROM_DQ_IN = vecs[v].dq;
            case (vecs[v].src)
                2'd0: begin SNES_RD_START = 1'b1; ROM_HIT = vecs[v].en; ROM_ADDR = vecs[v].addr; end
                2'd1: begin SNES_WR_END = 1'b1; IS_WRITABLE = vecs[v].en; ROM_ADDR = vecs[v].addr;
                            SNES_DATA_IN = vecs[v].data; end
                2'd2: begin MCU_RRQ = 1'b1; MCU_ADDR = vecs[v].addr; end
                default: begin MCU_WRQ = 1'b1; MCU_ADDR = vecs[v].addr; MCU_DOUT = vecs[v].data; end
            endcase
            for (int c = 0; c < L + 2; c++) begin
                step();
                if (!rif.ROM_CE_N) ce_low++;
                if (!rif.ROM_OE_N) oe_low++;
                if (!rif.ROM_WE_N) we_low++;
                if (!rif.ROM_CE_N && !got_a_seen) begin
                    got_a_seen = 1'b1; got_a = rif.ROM_A; got_bhe = rif.ROM_BHE_N;
                    got_ble = rif.ROM_BLE_N; got_dq = rif.ROM_DQ_OUT;
                end
            end
            exp_oe = (vecs[v].exp_cyc && !vecs[v].src[0]) ? L : 0;
            exp_we = (vecs[v].exp_cyc && vecs[v].src[0]) ? L - 1 : 0;
            check($sformatf("vec%0d_ce_clocks", v), 32'(ce_low), vecs[v].exp_cyc ? L : 0);
            check($sformatf("vec%0d_oe_clocks", v), 32'(oe_low), 32'(exp_oe));
            check($sformatf("vec%0d_we_clocks", v), 32'(we_low), 32'(exp_we));
            if (vecs[v].exp_cyc) begin
                check($sformatf("vec%0d_rom_a", v), 32'(got_a), 32'(vecs[v].exp_a));
                check($sformatf("vec%0d_lanes", v), {30'h0, got_bhe, got_ble},
                      {30'h0, vecs[v].exp_bhe_n, vecs[v].exp_ble_n});
                if (vecs[v].src[0])
                    check($sformatf("vec%0d_dq_out", v), 32'(got_dq), {16'h0, vecs[v].data, vecs[v].data});
                else if (vecs[v].src == 2'd0)
                    check($sformatf("vec%0d_snes_dout", v), 32'(SNES_DOUT), 32'(vecs[v].exp_rd));
                else
                    check($sformatf("vec%0d_mcu_din", v), 32'(MCU_DIN), 32'(vecs[v].exp_rd));
            end
        end

        // Simultaneous SNES and MCU reads: SNES first, one idle clock, then MCU.
        ROM_HIT = 1'b1; rif.ROM_DQ_IN = 16'h5AC3;
        SNES_RD_START = 1'b1; ROM_ADDR = 24'h000222; MCU_RRQ = 1'b1; MCU_ADDR = 24'h000333;
        step();
        check("sim_snes_first_a", 32'(rif.ROM_A), 32'h000111);
        check("sim_snes_oe", 32'(rif.ROM_OE_N), 32'h0);
        check("sim_rdy_low", 32'(MCU_RDY), 32'h0);
        for (int c = 0; c < L - 1; c++) step();
        step();
        check("sim_gap_ce", 32'(rif.ROM_CE_N), 32'h1);
        check("sim_gap_rdy", 32'(MCU_RDY), 32'h0);
        check("sim_snes_dout", 32'(SNES_DOUT), 32'hC3);
        step();
        check("sim_mcu_a", 32'(rif.ROM_A), 32'h000199);
        check("sim_mcu_ce", 32'(rif.ROM_CE_N), 32'h0);
        for (int c = 0; c < L - 1; c++) begin
            step();
            check("sim_mcu_rdy_busy", 32'(MCU_RDY), 32'h0);
        end
        step();
        check("sim_mcu_rdy_done", 32'(MCU_RDY), 32'h1);
        check("sim_mcu_din", 32'(MCU_DIN), 32'h5A);
        step();

        // Two SNES reads during an MCU write: only the later address is serviced.
        n_starts = 0;
        MCU_WRQ = 1'b1; MCU_ADDR = 24'h000400; MCU_DOUT = 8'h77;
        step(); step();
        SNES_RD_START = 1'b1; ROM_ADDR = 24'h001000;
        step(); step();
        SNES_RD_START = 1'b1; ROM_ADDR = 24'h002001;
        for (int c = 0; c < 14; c++) step();
        check("ovw_cycle_count", 32'(n_starts), 32'd2);
        check("ovw_addr", 32'(last_a), 32'h001000);
        check("ovw_is_read", 32'(last_oe), 32'h0);

        // Reset while an SNES read sits at count 2.
        rif.ROM_DQ_IN = 16'h9966;
        SNES_RD_START = 1'b1; ROM_ADDR = 24'h000010;
        step(); step(); step(); step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_strobes", {26'h0, rif.ROM_CE_N, rif.ROM_OE_N, rif.ROM_WE_N, rif.ROM_BHE_N,
                              rif.ROM_BLE_N, rif.ROM_DQ_OE}, 32'h3E);
        check("rst_snes_dout", 32'(SNES_DOUT), 32'h0);
        check("rst_mcu_rdy", 32'(MCU_RDY), 32'h1);
        n_starts = 0;
        for (int c = 0; c < 10; c++) step();
        check("rst_no_cycles", 32'(n_starts), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            RST = ($urandom_range(0, 299) == 0);
            rif.ROM_DQ_IN = 16'($urandom);
            ROM_ADDR = 24'($urandom); MCU_ADDR = 24'($urandom);
            SNES_DATA_IN = 8'($urandom); MCU_DOUT = 8'($urandom);
            ROM_HIT = ($urandom_range(0, 3) != 0);
            IS_WRITABLE = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r == 0) SNES_RD_START = 1'b1;
            else if (r == 1) SNES_WR_END = 1'b1;
            if ((!act.v || m_slot.v || act.mcu) && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) MCU_RRQ = 1'b1;
                else MCU_WRQ = 1'b1;
            end
            step();
        end
        RST = 1'b0;
        for (int c = 0; c < 2 * L + 4; c++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_access_seq.md
ROM_ACCESS_SEQ -- requirements
Module: rom_access_seq

Interface
REQ-001 Parameter ROM_CYCLE_LEN, default 6, SHALL set the clocks each external memory cycle holds its strobes (legal 3..15).
REQ-002 Port CLK  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 Port RST  in  1  reset, synchronous and active-high.
REQ-004 Port SNES_RD_START  in  1  one-clock pulse: synchronized SNES read strobe falling edge.
REQ-005 Port SNES_WR_END  in  1  one-clock pulse: synchronized SNES write strobe rising edge.
REQ-006 Port ROM_ADDR  in  24  translated byte address from the address decoder.
REQ-007 Port ROM_HIT  in  1  decoder: access targets cartridge memory.
REQ-008 Port IS_WRITABLE  in  1  decoder: address writable (save RAM / BS-X RAM).
REQ-009 Port SNES_DATA_IN  in  8  SNES write data, valid with SNES_WR_END.
REQ-010 Port SNES_DOUT  out  8  last SNES read byte.
REQ-011 Ports MCU_RRQ, MCU_WRQ  in  1 each  one-clock MCU read/write request pulses.
REQ-012 Ports MCU_ADDR  in  24; MCU_DOUT  in  8  MCU address and write data, valid with the request pulse.
REQ-013 Ports MCU_RDY  out  1; MCU_DIN  out  8  MCU idle flag and read result.
REQ-014 Ports ROM_A  out  23 word address; ROM_DQ_IN  in  16; ROM_DQ_OUT  out  16; ROM_DQ_OE  out  1.
REQ-015 Ports ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N  out  1 each, active-low strobes.

Function
REQ-016 FSM states SHALL be IDLE, SRD, SWR, MRD, MWR; a 4-bit down-counter CNT times each cycle.
REQ-017 SNES_RD_START SHALL be accepted only if ROM_HIT=1; SNES_WR_END only if IS_WRITABLE=1; rejected pulses SHALL cause no memory cycle.
REQ-018 Accepted requests SHALL latch address (and write data) on the pulse clock into a pending slot; one SNES slot, one MCU slot.
REQ-019 A new SNES pulse while SNES slot full SHALL overwrite it; MCU pulse while MCU slot full or cycle active SHALL be dropped.
REQ-020 From IDLE with pending requests, SNES slot SHALL win over MCU slot; simultaneous pulses in same clock: SNES first, MCU kept pending.
REQ-021 Pulse in IDLE with no pending SHALL start the cycle on that same edge: state SRD/SWR/MRD/MWR, CNT=ROM_CYCLE_LEN-1.
REQ-022 During a cycle: ROM_CE_N=0; reads ROM_OE_N=0; writes ROM_WE_N=0 while CNT!=0, 1 at CNT=0; ROM_DQ_OE=1 for whole write cycle.
REQ-023 ROM_A SHALL be addr[23:1]; addr[0]=0 asserts ROM_BLE_N=0, addr[0]=1 asserts ROM_BHE_N=0; other lane stays 1.
REQ-024 Writes SHALL drive the data byte on both halves of ROM_DQ_OUT.
REQ-025 At CNT=0 of a read, selected byte of ROM_DQ_IN SHALL load SNES_DOUT (SRD) or MCU_DIN (MRD); state SHALL go IDLE.
REQ-026 Every cycle SHALL be followed by at least one IDLE clock with all strobes 1 and ROM_DQ_OE=0 before the next cycle.
REQ-027 Read data valid ROM_CYCLE_LEN clocks after the accepting edge; total occupancy ROM_CYCLE_LEN+1 clocks.
REQ-028 MCU_RDY SHALL be 0 from the clock after an accepted MCU pulse until the clock after its cycle's CNT=0, else 1.
REQ-029 Arithmetic: CNT SHALL decrement by one per clock, never wrap; no address increment inside block.

Reset
REQ-030 RST=1 SHALL force IDLE, CNT=0, both slots empty, all strobes 1, ROM_DQ_OE=0, ROM_A=0, ROM_DQ_OUT=0, SNES_DOUT=0, MCU_DIN=0, MCU_RDY=1.
REQ-031 RST mid-cycle SHALL abort the cycle on that edge; pulses coincident with RST SHALL be discarded.

Verification
REQ-032 SNES read, ROM_ADDR=0x012345, ROM_HIT=1, ROM_DQ_IN=0xA55A -> ROM_A=0x0091A2, BHE_N=0, OE_N low 6 clocks, SNES_DOUT=0xA5 at 6th edge.
REQ-033 SNES write, IS_WRITABLE=0 -> no strobe activity; repeat with IS_WRITABLE=1, addr 0xE00010, data 0x3C -> ROM_DQ_OUT=0x3C3C, BLE_N=0, WE_N low 5 clocks, high 6th.
REQ-034 MCU_RRQ and SNES_RD_START same clock -> SNES cycle first, 1 IDLE clock, then MCU cycle; MCU_RDY 0 throughout, 1 after MCU_DIN loads.
REQ-035 Two SNES_RD_START pulses during an MCU write -> only second address read after MCU cycle; one SNES cycle total.
REQ-036 RST asserted at CNT=2 of SRD -> next clock all strobes 1, SNES_DOUT=0, MCU_RDY=1, no further cycles.
